// File: rtl/mult_rr_if.sv
// Request/result bundle between client blocks and the shared multiplier scheduler.
// The clients hold the master side; the scheduler holds the slave side.
interface mult_rr_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [2*WIDTH-1:0]    res_data;
    logic [1:0]            res_id;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// One iterative shift-add multiplier shared by four requesters under round-robin
// arbitration, with valid/ready handshakes on the request ports and the result port.
module mult_rr_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    mult_rr_if.slave   bus
);
    localparam int NREQ  = 4;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [1:0]         id;
    logic [1:0]         last_grant;
    logic               res_valid_q;
    logic [2*WIDTH-1:0] res_data_q;
    logic [1:0]         res_id_q;

    logic               grant_any;
    logic [1:0]         grant_idx;
    logic [2*WIDTH-1:0] acc_next;

    // Search starts just past the last served requester so it ends up lowest priority.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!grant_any && bus.req_valid[2'(last_grant + 2'(off))]) begin
                grant_any = 1'b1;
                grant_idx = 2'(last_grant + 2'(off));
            end
        end
    end

    assign acc_next = acc + (b_reg[0] ? a_reg : '0);

    assign bus.req_ready = (state == IDLE && grant_any) ? (NREQ'(1) << grant_idx) : '0;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = (state != IDLE);

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too; the block holds no memory arrays,
            // so the cost is small and res_data leaves reset at a defined zero.
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            id          <= 2'd0;
            last_grant  <= 2'd3;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_reg      <= {{WIDTH{1'b0}}, bus.req_a[grant_idx*WIDTH +: WIDTH]};
                        b_reg      <= bus.req_b[grant_idx*WIDTH +: WIDTH];
                        acc        <= '0;
                        count      <= '0;
                        id         <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    count <= count + 1'b1;
                    // The final iteration's sum goes straight to the result register.
                    if (count == LAST) begin
                        res_data_q  <= acc_next;
                        res_id_q    <= id;
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler: grants push expected products, results pop them.
module tb_mult_rr_scheduler;
    localparam int W = 8;

    typedef struct {
        logic [1:0]     id;
        logic [2*W-1:0] prod;
    } exp_t;

    logic clk;
    logic rst;
    mult_rr_if #(.WIDTH(W), .NREQ(4)) bus ();

    mult_rr_scheduler #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   grant_log[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: a grant seen before the edge becomes an expected result; a result
    // handshake seen before the edge is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    mon_e.id   = 2'(i);
                    mon_e.prod = (2*W)'(bus.req_a[i*W +: W]) * (2*W)'(bus.req_b[i*W +: W]);
                    sb.push_back(mon_e);
                    grant_log.push_back(i);
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_result: got id %0d data %0d, expected no result",
                             bus.res_id, bus.res_data);
                end else begin
                    mon_e = sb.pop_front();
                    if ({bus.res_id, bus.res_data} !== {mon_e.id, mon_e.prod})
                        $display("FAIL result: got id %0d data %0d, expected id %0d data %0d",
                                 bus.res_id, bus.res_data, mon_e.id, mon_e.prod);
                    else
                        n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Present one request, wait for its grant, then return at the first sample showing
    // res_valid; lat counts rising edges from the accepting edge to that sample.
    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit mutate, output int lat);
        int k;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid[i]    = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.req_ready[i] && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (bus.req_ready !== (4'b0001 << i))
            $display("FAIL grant_%0d: got req_ready %b, expected %b", i, bus.req_ready, 4'b0001 << i);
        else
            n_pass++;
        @(posedge clk);
        #1;
        bus.req_valid[i] = 1'b0;
        if (mutate) begin
            bus.req_a[i*W +: W] = ~a;
            bus.req_b[i*W +: W] = ~b;
        end
        for (lat = 1; lat <= 40; lat++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.res_valid) break;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while ((bus.busy || sb.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (bus.busy !== 1'b0 || sb.size() != 0)
            $display("FAIL drain: got busy %b pending %0d, expected busy 0 pending 0", bus.busy, sb.size());
        else
            n_pass++;
        @(posedge clk);
        #1;
    endtask

    // Hold the masked requesters valid until n grants have been logged.
    task automatic run_group(input logic [3:0] mask, input int n);
        int k;
        grant_log.delete();
        bus.req_valid = mask;
        k = 0;
        while (grant_log.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 4'b0000;
        wait_idle(60);
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.res_valid, bus.res_data, bus.res_id, bus.busy, bus.req_ready} !== {1'b0, 16'd0, 2'd0, 1'b0, 4'b0000})
            $display("FAIL reset_state: got valid %b data %0d id %0d busy %b ready %b, expected all zero",
                     bus.res_valid, bus.res_data, bus.res_id, bus.busy, bus.req_ready);
        else
            n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        int lat;
        bus.res_ready = 1'b1;
        issue(0, 8'd13, 8'd11, 1'b0, lat);
        n_checks++;
        if (lat != W) $display("FAIL single_latency: got %0d, expected %0d", lat, W);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL single_busy_done: got %b, expected 1", bus.busy);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.res_valid} !== 2'b00)
            $display("FAIL single_after_accept: got busy %b valid %b, expected 0 0", bus.busy, bus.res_valid);
        else
            n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_boundary;
        int lat;
        logic [W-1:0] av[3];
        logic [W-1:0] bv[3];
        av = '{8'd255, 8'd0, 8'd1};
        bv = '{8'd255, 8'd200, 8'd128};
        for (int t = 0; t < 3; t++) begin
            issue(t + 1, av[t], bv[t], 1'b0, lat);
            n_checks++;
            if (lat != W) $display("FAIL boundary_latency_%0d: got %0d, expected %0d", t, lat, W);
            else n_pass++;
            wait_idle(10);
        end
    endtask

    task automatic test_round_robin;
        int order[5];
        int got;
        order = '{0, 1, 2, 3, 0};
        bus.req_a = {8'd128, 8'd17, 8'd200, 8'd3};
        bus.req_b = {8'd255, 8'd17, 8'd2, 8'd5};
        run_group(4'b1111, 5);
        for (int k = 0; k < 5; k++) begin
            got = (k < grant_log.size()) ? grant_log[k] : -1;
            n_checks++;
            if (got != order[k]) $display("FAIL rr_order_%0d: got %0d, expected %0d", k, got, order[k]);
            else n_pass++;
        end
    endtask

    task automatic test_operand_change;
        int lat;
        issue(1, 8'd20, 8'd3, 1'b1, lat);
        n_checks++;
        if (lat != W) $display("FAIL opchange_latency: got %0d, expected %0d", lat, W);
        else n_pass++;
        wait_idle(10);
    endtask

    task automatic test_reset_mid_busy;
        int k;
        int got;
        bus.req_a[1*W +: W] = 8'd50;
        bus.req_b[1*W +: W] = 8'd50;
        bus.req_valid[1]    = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.req_ready[1] && k < 60) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.res_valid, bus.res_data} !== {1'b0, 1'b0, 16'd0})
            $display("FAIL mid_reset_state: got busy %b valid %b data %0d, expected 0 0 0",
                     bus.busy, bus.res_valid, bus.res_data);
        else
            n_pass++;
        @(posedge clk);
        #1;
        // With last_grant back at 3, requester 1 must win over requester 2.
        bus.req_a[1*W +: W] = 8'd3;
        bus.req_b[1*W +: W] = 8'd4;
        bus.req_a[2*W +: W] = 8'd7;
        bus.req_b[2*W +: W] = 8'd6;
        run_group(4'b0110, 2);
        for (int j = 0; j < 2; j++) begin
            got = (j < grant_log.size()) ? grant_log[j] : -1;
            n_checks++;
            if (got != j + 1) $display("FAIL mid_reset_order_%0d: got %0d, expected %0d", j, got, j + 1);
            else n_pass++;
        end
    endtask

    task automatic test_back_pressure;
        int lat;
        bus.res_ready       = 1'b0;
        bus.req_a[0*W +: W] = 8'd5;
        bus.req_b[0*W +: W] = 8'd6;
        bus.req_valid[0]    = 1'b1;
        issue(3, 8'd9, 8'd10, 1'b0, lat);
        n_checks++;
        if (lat != W) $display("FAIL bp_latency: got %0d, expected %0d", lat, W);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({bus.res_valid, bus.res_id, bus.res_data, bus.req_ready} !== {1'b1, 2'd3, 16'd90, 4'b0000})
                $display("FAIL bp_hold_%0d: got valid %b id %0d data %0d ready %b, expected 1 3 90 0000",
                         k, bus.res_valid, bus.res_id, bus.res_data, bus.req_ready);
            else
                n_pass++;
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0000) $display("FAIL bp_no_grant_in_done: got %b, expected 0000", bus.req_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.busy} !== {4'b0001, 1'b0})
            $display("FAIL bp_next_grant: got ready %b busy %b, expected 0001 0", bus.req_ready, bus.busy);
        else
            n_pass++;
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        wait_idle(20);
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_round_robin();
        test_operand_change();
        test_reset_mid_busy();
        test_back_pressure();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one iterative shift-add unsigned multiplier among 4 requesters.
- Round-robin arbitration between requesters, with valid/ready handshakes on each request port and on the result port.
- Sits between several client blocks and a single multiply resource. This replaces per-client full combinational array multipliers where throughput is not critical.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- NREQ, 4, number of requesters; fixed at 4, and the id field is 2 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  4  per-requester request valid.
- req_ready  output  4  per-requester accept; one-hot or zero.
- req_a  input  4*WIDTH  multiplicands; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  4*WIDTH  multipliers; same packing as req_a.
- res_valid  output  1  result valid.
- res_ready  input  1  result consumer ready.
- res_data  output  2*WIDTH  product a*b.
- res_id  output  2  index of the requester that owns res_data.
- busy  output  1  high whenever the FSM state is not IDLE.

Behaviour:
- Reset (rst high at a clock edge) forces:
  - state=IDLE, count=0, accumulator=0;
  - res_valid=0, res_data=0, res_id=0;
  - last_grant=3, so requester 0 has top priority after reset.
- Reset mid-operation aborts the multiply with no result produced and no requester notified.
- States are IDLE, BUSY, DONE.
- IDLE:
  - req_ready is combinational. It is one-hot on the first requester with req_valid high, searching last_grant+1, +2, +3, +4 (mod 4). It is zero if no request is valid.
  - On the edge where req_valid[i] and req_ready[i] are both high:
    - latch a=req_a[i] (zero-extended to 2*WIDTH) and b=req_b[i];
    - acc=0, count=0, id=i, last_grant=i;
    - go to BUSY.
- BUSY:
  - req_ready=0.
  - Each edge: if b[0] is 1, acc=acc+a (2*WIDTH bits, which cannot overflow). Then a<<=1, b>>=1, count++.
  - When count reaches WIDTH-1, that edge performs the last iteration and transitions to DONE. It also loads res_data with the final acc, res_id=id, res_valid=1.
- DONE:
  - res_valid=1. res_data and res_id are held stable until the result is accepted.
  - On the edge with res_ready=1: res_valid goes to 0 and state goes to IDLE. res_data keeps its last value.
  - req_ready=0 in DONE. A new grant is earliest in the cycle after the result is accepted.
- Latency:
  - res_valid rises in the cycle following the WIDTH-th edge after the accepting edge.
  - Minimum initiation interval is WIDTH+2 cycles when res_ready is held high.
- Fairness:
  - A requester that has just been served has lowest priority next time.
  - Requests not granted remain pending. A requester may drop req_valid before being granted without side effects.
- Operands are sampled only at the accepting edge. Changes to req_a or req_b afterwards do not affect the result.
- Zero operands still take the full WIDTH iterations; there is no early termination.
- busy=0 iff state is IDLE.

Test Plan:
- Reset, then a single request: req_valid=0001, a=13, b=11 -> req_ready=0001 for one cycle; res_valid 8 edges later; res_data=143, res_id=0; busy high from acceptance until the result is accepted.
- Boundary values: a=255, b=255 -> 65025. Also a=0, b=200 -> 0 with the same latency. Also a=1, b=128 -> 128.
- Round robin: all four request continuously with distinct operands -> grant order 0,1,2,3,0. Every res_id matches its product. No requester is served twice before all four are served.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_valid, res_data and res_id are stable; req_ready=0 throughout; the next grant comes the cycle after res_ready=1.
- Operand change after accept: change req_a[1] during BUSY -> result uses the latched value.
- Reset mid-BUSY: assert rst at count=3 -> next cycle IDLE, res_valid=0, last_grant=3. A subsequent request from requester 2 with a=7, b=6 gives res_data=42, res_id=2.
